// File: rtl/opp_pkt_pkg.sv
// rtl/opp_pkt_pkg.sv - opponent-state packet constants, field layout and receiver FSM states
// Purpose: shared definitions for the opponent-state receive path.
//   Frame: B0 sync, B1 sequence, B2..B6 40-bit payload (B2 MSB), B7 XOR of B1..B6.
//   Payload: [39:29] x, [28:18] y, [17:9] dir, [8:6] game, [5:0] pad.
package opp_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [3:0] FRAME_BYTES   = 4'd8;

  localparam int PAYLOAD_W = 40;
  localparam int X_W       = 11;
  localparam int Y_W       = 11;
  localparam int DIR_W     = 9;
  localparam int GAME_W    = 3;
  localparam int PAD_W     = 6;

  localparam int X_LSB     = 29;
  localparam int Y_LSB     = 18;
  localparam int DIR_LSB   = 9;
  localparam int GAME_LSB  = 6;

  // Only the non-pad payload bits are kept by the receiver.
  localparam int FIELDS_W  = PAYLOAD_W - PAD_W;

  localparam logic [DIR_W-1:0] DIR_MAX = 9'd359;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK,
    DROP
  } rx_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/opp_state_rx_link_timer.sv
// rtl/opp_state_rx_link_timer.sv - saturating link-liveness timer
// Purpose: counts cycles since the last good frame.
// Ports:
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset (presets the count to TIMEOUT_CYCLES, link down)
//   kick     in  clears the count (a good frame was accepted)
//   link_up  out high while the count is below TIMEOUT_CYCLES
module link_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  output logic link_up
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= TIMEOUT_CYCLES;
    end else if (kick) begin
      count <= '0;
    end else if (count < TIMEOUT_CYCLES) begin
      count <= count + 32'd1;
    end
  end

  assign link_up = (count < TIMEOUT_CYCLES);

endmodule

// File: rtl/opp_state_rx.sv
// rtl/opp_state_rx.sv - opponent kart state packet receiver
// Purpose: frames, validates and unpacks 8-byte opponent-state packets from a byte stream.
// Optional build macro: OPP_SEQ_CHECK_EN rejects a frame repeating the last accepted sequence number.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   axiiv, axiid   byte valid / byte data; a frame is one contiguous run of valid cycles
//   r_opp_x/y      opponent position of the last accepted frame
//   r_opp_dir      opponent heading, 0..359
//   r_opp_game     opponent game status
//   receive_axiov  one-cycle pulse when the four fields above update
//   link_up        high while a good frame arrived within TIMEOUT_CYCLES
//   err_count      saturating rejected-frame count
module opp_state_rx
  import opp_pkt_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [10:0] RESET_X        = 11'd300,
  parameter logic [10:0] RESET_Y        = 11'd100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        axiiv,
  input  logic [7:0]  axiid,
  output logic [10:0] r_opp_x,
  output logic [10:0] r_opp_y,
  output logic [8:0]  r_opp_dir,
  output logic [2:0]  r_opp_game,
  output logic        receive_axiov,
  output logic        link_up,
  output logic [7:0]  err_count
);

  rx_state_t             state;
  rx_state_t             phase;
  logic [3:0]            byte_cnt;
  logic                  sync_ok;
  logic [7:0]            xor_acc;
  logic [7:0]            chk_byte;
  logic [FIELDS_W-1:0]   fields;
  logic [X_W-1:0]        x_f;
  logic [Y_W-1:0]        y_f;
  logic [DIR_W-1:0]      dir_f;
  logic [GAME_W-1:0]     game_f;
  logic                  seq_ok;
  logic                  frame_ok;
  logic                  accept;

  // fields holds payload bits [39:PAD_W], so offsets shift down by PAD_W.
  assign x_f    = fields[X_LSB-PAD_W    +: X_W];
  assign y_f    = fields[Y_LSB-PAD_W    +: Y_W];
  assign dir_f  = fields[DIR_LSB-PAD_W  +: DIR_W];
  assign game_f = fields[GAME_LSB-PAD_W +: GAME_W];

  // The first low cycle after bytes is evaluated in the same cycle, so the FSM is
  // back in IDLE for a frame starting right after a single gap cycle.
  always_comb begin
    phase = state;
    if (state == RECV && !axiiv) phase = CHECK;
  end

`ifdef OPP_SEQ_CHECK_EN
  logic [7:0] seq_byte;
  logic [7:0] last_seq;
  logic       seq_valid;
  assign seq_ok = !(seq_valid && (seq_byte == last_seq));
`else
  assign seq_ok = 1'b1;
`endif

  assign frame_ok = (byte_cnt == FRAME_BYTES) && sync_ok && (chk_byte == xor_acc) &&
                    (dir_f <= DIR_MAX) && seq_ok;
  assign accept   = (phase == CHECK) && frame_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      sync_ok       <= 1'b0;
      xor_acc       <= '0;
      chk_byte      <= '0;
      fields        <= '0;
      r_opp_x       <= RESET_X;
      r_opp_y       <= RESET_Y;
      r_opp_dir     <= '0;
      r_opp_game    <= '0;
      receive_axiov <= 1'b0;
      err_count     <= '0;
`ifdef OPP_SEQ_CHECK_EN
      seq_byte      <= '0;
      last_seq      <= '0;
      seq_valid     <= 1'b0;
`endif
    end else begin
      receive_axiov <= 1'b0;
      case (phase)
        IDLE: begin
          if (axiiv) begin
            sync_ok  <= (axiid == SYNC_BYTE);
            byte_cnt <= 4'd1;
            xor_acc  <= '0;
            state    <= RECV;
          end
        end
        RECV: begin
          if (byte_cnt == FRAME_BYTES) begin
            state <= DROP;
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt <= 4'd6) xor_acc <= xor_acc ^ axiid;
            if (byte_cnt >= 4'd2 && byte_cnt <= 4'd5) fields <= {fields[FIELDS_W-9:0], axiid};
            // Last payload byte: only its top bits are fields, the rest is pad.
            if (byte_cnt == 4'd6) fields <= {fields[FIELDS_W-3:0], axiid[7:6]};
            if (byte_cnt == 4'd7) chk_byte <= axiid;
`ifdef OPP_SEQ_CHECK_EN
            if (byte_cnt == 4'd1) seq_byte <= axiid;
`endif
          end
        end
        CHECK: begin
          state <= IDLE;
          if (frame_ok) begin
            r_opp_x       <= x_f;
            r_opp_y       <= y_f;
            r_opp_dir     <= dir_f;
            r_opp_game    <= game_f;
            receive_axiov <= 1'b1;
`ifdef OPP_SEQ_CHECK_EN
            last_seq      <= seq_byte;
            seq_valid     <= 1'b1;
`endif
          end else begin
            err_count <= sat_inc8(err_count);
          end
        end
        DROP: begin
          // One error per overlength frame, charged when the run of bytes ends.
          if (!axiiv) begin
            state     <= IDLE;
            err_count <= sat_inc8(err_count);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  link_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_link_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .kick    (accept),
    .link_up (link_up)
  );

endmodule

// File: tb/tb_opp_state_rx.sv
// tb/tb_opp_state_rx.sv - self-checking bench for opp_state_rx
module tb_opp_state_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        axiiv = 1'b0;
  logic [7:0]  axiid = 8'd0;
  logic [10:0] r_opp_x;
  logic [10:0] r_opp_y;
  logic [8:0]  r_opp_dir;
  logic [2:0]  r_opp_game;
  logic        receive_axiov;
  logic        link_up;
  logic [7:0]  err_count;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int pulse_prev = -1;
  int pulse_last = -1;

  opp_state_rx #(
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .axiiv         (axiiv),
    .axiid         (axiid),
    .r_opp_x       (r_opp_x),
    .r_opp_y       (r_opp_y),
    .r_opp_dir     (r_opp_dir),
    .r_opp_game    (r_opp_game),
    .receive_axiov (receive_axiov),
    .link_up       (link_up),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  dir;
    logic [2:0]  game;
    logic [7:0]  seq;
    int          len;
    bit          bad_sync;
    bit          bad_chk;
    bit          exp_accept;
  } vec_t;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  dir;
    logic [2:0]  game;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];

  logic [10:0] m_x = 11'd300;
  logic [10:0] m_y = 11'd100;
  logic [8:0]  m_dir = 9'd0;
  logic [2:0]  m_game = 3'd0;
  logic [7:0]  m_err = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name);
    chk({name, "_x"},    32'(r_opp_x),    32'(m_x));
    chk({name, "_y"},    32'(r_opp_y),    32'(m_y));
    chk({name, "_dir"},  32'(r_opp_dir),  32'(m_dir));
    chk({name, "_game"}, 32'(r_opp_game), 32'(m_game));
    chk({name, "_err"},  32'(err_count),  32'(m_err));
  endtask

  // Scoreboard side: every pulse must match the oldest expected accept.
  always @(negedge clk) begin
    if (rst_n && receive_axiov) begin
      pulse_prev = pulse_last;
      pulse_last = cyc;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=1 required=0 cycle=%0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("pulse_x", 32'(r_opp_x), 32'(e.x));
        chk("pulse_y", 32'(r_opp_y), 32'(e.y));
        chk("pulse_dir", 32'(r_opp_dir), 32'(e.dir));
        chk("pulse_game", 32'(r_opp_game), 32'(e.game));
        chk("pulse_link_up", 32'(link_up), 32'd1);
      end
    end
  end

  // Drives one frame; rst_at >= 0 pulls reset low from that byte index onward.
  task automatic send_frame(input vec_t v, input int rst_at, output int n_last);
    logic [7:0]  b[9];
    logic [39:0] p;
    logic [7:0]  x;
    p = {v.x, v.y, v.dir, v.game, 6'd0};
    b[0] = v.bad_sync ? 8'h5A : 8'hA5;
    b[1] = v.seq;
    b[2] = p[39:32];
    b[3] = p[31:24];
    b[4] = p[23:16];
    b[5] = p[15:8];
    b[6] = p[7:0];
    x = 8'd0;
    for (int i = 1; i <= 6; i++) x = x ^ b[i];
    b[7] = v.bad_chk ? (x ^ 8'h01) : x;
    b[8] = 8'h3C;
    n_last = cyc;
    for (int i = 0; i < v.len; i++) begin
      @(negedge clk);
      if (i == rst_at) rst_n = 1'b0;
      axiiv = 1'b1;
      axiid = b[i];
      n_last = cyc;
    end
    @(negedge clk);
    axiiv = 1'b0;
    axiid = 8'd0;
  endtask

  task automatic expect_result(input vec_t v, input int n_last);
    exp_t e;
    if (v.exp_accept) begin
      e.x = v.x; e.y = v.y; e.dir = v.dir; e.game = v.game; e.cyc = n_last + 2;
      sb.push_back(e);
      m_x = v.x; m_y = v.y; m_dir = v.dir; m_game = v.game;
    end else begin
      m_err = (m_err == 8'hFF) ? m_err : m_err + 8'd1;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    send_frame(v, -1, n);
    expect_result(v, n);
    repeat (3) @(negedge clk);
    chk_state(name);
  endtask

  function automatic vec_t mk(input logic [10:0] x, input logic [10:0] y, input logic [8:0] dir,
                              input logic [2:0] game, input logic [7:0] seq, input int len,
                              input bit bs, input bit bc, input bit acc);
    vec_t v;
    v.x = x; v.y = y; v.dir = dir; v.game = game; v.seq = seq;
    v.len = len; v.bad_sync = bs; v.bad_chk = bc; v.exp_accept = acc;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    int n2;
    int p;
    vec_t v;

    vecs[0] = mk(11'd500,  11'd200, 9'd90,  3'd1, 8'd1, 8, 1'b0, 1'b1, 1'b0);
    vecs[1] = mk(11'd500,  11'd200, 9'd90,  3'd1, 8'd1, 8, 1'b0, 1'b0, 1'b1);
    vecs[2] = mk(11'd600,  11'd250, 9'd45,  3'd2, 8'd2, 7, 1'b0, 1'b0, 1'b0);
    vecs[3] = mk(11'd600,  11'd250, 9'd45,  3'd2, 8'd2, 9, 1'b0, 1'b0, 1'b0);
    vecs[4] = mk(11'd600,  11'd250, 9'd360, 3'd2, 8'd2, 8, 1'b0, 1'b0, 1'b0);
    vecs[5] = mk(11'd600,  11'd250, 9'd45,  3'd2, 8'd2, 8, 1'b1, 1'b0, 1'b0);
    vecs[6] = mk(11'd2047, 11'd0,   9'd359, 3'd7, 8'd3, 8, 1'b0, 1'b0, 1'b1);
    vecs[7] = mk(11'd10,   11'd20,  9'd0,   3'd2, 8'd7, 8, 1'b0, 1'b0, 1'b1);
`ifdef OPP_SEQ_CHECK_EN
    vecs[8] = mk(11'd11,   11'd21,  9'd180, 3'd3, 8'd7, 8, 1'b0, 1'b0, 1'b0);
`else
    vecs[8] = mk(11'd11,   11'd21,  9'd180, 3'd3, 8'd7, 8, 1'b0, 1'b0, 1'b1);
`endif

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_state("reset");
    chk("reset_axiov", 32'(receive_axiov), 32'd0);
    chk("reset_link_up", 32'(link_up), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Two good frames with a single low cycle between them.
    v = mk(11'd100, 11'd110, 9'd10, 3'd4, 8'd20, 8, 1'b0, 1'b0, 1'b1);
    send_frame(v, -1, n1);
    expect_result(v, n1);
    v = mk(11'd900, 11'd910, 9'd300, 3'd5, 8'd21, 8, 1'b0, 1'b0, 1'b1);
    send_frame(v, -1, n2);
    expect_result(v, n2);
    repeat (3) @(negedge clk);
    chk("b2b_pulse_gap", 32'(pulse_last - pulse_prev), 32'd9);
    chk_state("b2b");

    // Link timeout: up 19 cycles after the pulse, down at 20.
    v = mk(11'd123, 11'd45, 9'd270, 3'd6, 8'd30, 8, 1'b0, 1'b0, 1'b1);
    send_frame(v, -1, n1);
    expect_result(v, n1);
    p = n1 + 2;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cyc == p + 19) chk("link_up_before_timeout", 32'(link_up), 32'd1);
      if (cyc == p + 20) chk("link_up_after_timeout", 32'(link_up), 32'd0);
    end

    // Reset in the middle of a good frame: remaining bytes are discarded.
    v = mk(11'd700, 11'd710, 9'd100, 3'd1, 8'd40, 8, 1'b0, 1'b0, 1'b1);
    send_frame(v, 4, n1);
    @(negedge clk);
    rst_n = 1'b1;
    m_x = 11'd300; m_y = 11'd100; m_dir = 9'd0; m_game = 3'd0; m_err = 8'd0;
    repeat (2) @(negedge clk);
    chk_state("midreset");
    chk("midreset_link_up", 32'(link_up), 32'd0);
    run_vec(v, "after_reset");

    // Saturation: many one-byte runt frames.
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      axiiv = 1'b1;
      axiid = 8'hA5;
      @(negedge clk);
      axiiv = 1'b0;
      axiid = 8'd0;
      m_err = (m_err == 8'hFF) ? m_err : m_err + 8'd1;
    end
    repeat (3) @(negedge clk);
    chk_state("saturate");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
